mem_wb_skid_register: RTL and testbench

Parametrised, elastic successor to the fixed MEM/WB pipeline register: it carries a control field, a data payload and a destination register index from the memory stage to write-back, with a valid/ready handshake on both sides. A two-entry skid buffer gives full throughput under back-pressure, and every output, including `in_ready`, comes straight from registers. A synchronous flush turns in-flight beats into bubbles.

---
 rtl/mem_wb_skid_register.sv | 108 ++++++++++
 tb/tb_mem_wb_skid_register.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_register.sv
// Elastic MEM/WB pipeline register: two-entry skid buffer with valid/ready on
// both sides, fully registered outputs and a synchronous flush.
module mem_wb_skid_register #(
  parameter int CTRL_W = 1,
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
  } entry_t;

  // Encoding chosen so bit 0 is the main valid and bit 1 the skid valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t state, state_n;
  entry_t main_q, main_n, skid_q, skid_n, in_entry;
  logic   main_valid, skid_valid, in_fire, out_fire;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_entry   = '{ctrl: in_ctrl, data: in_data, rd: in_rd};
  assign in_fire    = in_valid & ~skid_valid;
  assign out_fire   = main_valid & out_ready;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_n  = in_entry;
          state_n = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_n = in_entry;
        end else if (in_fire) begin
          skid_n  = in_entry;
          state_n = TWO;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_n  = skid_q;
          state_n = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    // Flush wins: contents are held (so a dropped input never reaches
    // out_data) and only ctrl/rd are scrubbed.
    if (flush) begin
      state_n     = EMPTY;
      main_n      = main_q;
      skid_n      = skid_q;
      main_n.ctrl = '0;
      main_n.rd   = '0;
      skid_n.ctrl = '0;
      skid_n.rd   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_q.ctrl : '0;
  assign out_rd    = main_valid ? main_q.rd : '0;
  assign out_data  = main_q.data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mem_wb_skid_register.sv
// Directed bench for mem_wb_skid_register: reset, streaming, back-pressure,
// flush, concurrent fire and skid drain, with hand-computed expectations.
module tb_mem_wb_skid_register;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [0:0]  in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [4:0]  in_rd, out_rd;
  logic [1:0]  occupancy;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_wb_skid_register #(.CTRL_W(1), .DATA_W(64), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic c, input logic [63:0] d, input logic [4:0] r);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_rd    = r;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 1'b0, 64'h0, 5'd0);
    step(); step();
    chk("por_out_valid", out_valid, 0);
    chk("por_in_ready", in_ready, 1);
    chk("por_occ", occupancy, 0);
    reset = 1'b0;

    // Reset mid-stream with two beats held.
    offer(1'b1, 1'b1, 64'h1, 5'd1); step();
    chk("fill1_occ", occupancy, 1);
    offer(1'b1, 1'b1, 64'h2, 5'd2); step();
    chk("fill2_occ", occupancy, 2);
    chk("fill2_in_ready", in_ready, 0);
    offer(1'b0, 1'b0, 64'h0, 5'd0);
    #2 reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    offer(1'b1, 1'b1, 64'hA, 5'd3); step();
    chk("post_rst_data", out_data, 64'hA);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_rd", out_rd, 3);
    chk("post_rst_ctrl", out_ctrl, 1);
    offer(1'b0, 1'b0, 64'h0, 5'd0); out_ready = 1'b1; step();
    chk("drain_occ", occupancy, 0);
    chk("empty_ctrl_mask", out_ctrl, 0);
    chk("empty_rd_mask", out_rd, 0);

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, 1'b0, 64'(i), 5'(i)); step();
      chk("stream_data", out_data, 64'(i));
      chk("stream_rd", out_rd, 64'(i));
      chk("stream_occ", occupancy, 1);
    end
    offer(1'b0, 1'b0, 64'h0, 5'd0); step();
    chk("stream_end_valid", out_valid, 0);

    // Back-pressure.
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 64'h11, 5'd1); step();
    chk("bp1_data", out_data, 64'h11);
    chk("bp1_in_ready", in_ready, 1);
    offer(1'b1, 1'b0, 64'h22, 5'd2); step();
    chk("bp2_occ", occupancy, 2);
    chk("bp2_in_ready", in_ready, 0);
    offer(1'b1, 1'b0, 64'h33, 5'd3); step();
    chk("bp3_data", out_data, 64'h11);
    chk("bp3_occ", occupancy, 2);
    out_ready = 1'b1; step();
    chk("bp_out2_data", out_data, 64'h22);
    chk("bp_out2_occ", occupancy, 1);
    chk("bp_out2_in_ready", in_ready, 1);
    step();
    chk("bp_out3_data", out_data, 64'h33);
    chk("bp_out3_rd", out_rd, 3);
    offer(1'b0, 1'b0, 64'h0, 5'd0); step();
    chk("bp_end_occ", occupancy, 0);

    // Flush while full, with a concurrent offer that must be dropped.
    out_ready = 1'b0;
    offer(1'b1, 1'b1, 64'h55, 5'd7); step();
    offer(1'b1, 1'b1, 64'h66, 5'd7); step();
    chk("fl_pre_occ", occupancy, 2);
    chk("fl_pre_ctrl", out_ctrl, 1);
    chk("fl_pre_rd", out_rd, 7);
    flush = 1'b1;
    offer(1'b1, 1'b0, 64'h44, 5'd4); step();
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_rd", out_rd, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_no_44_data", (out_data == 64'h44), 0);
    flush = 1'b0;
    offer(1'b0, 1'b0, 64'h0, 5'd0); out_ready = 1'b1; step();
    chk("fl_after_valid", out_valid, 0);
    chk("fl_after_no_44", (out_data == 64'h44), 0);

    // Simultaneous in-fire and out-fire in ONE.
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 64'h5, 5'd5); step();
    chk("sim_main", out_data, 64'h5);
    out_ready = 1'b1;
    offer(1'b1, 1'b0, 64'h6, 5'd6); step();
    chk("sim_data", out_data, 64'h6);
    chk("sim_occ", occupancy, 1);
    offer(1'b0, 1'b0, 64'h0, 5'd0); step();
    chk("sim_end_occ", occupancy, 0);

    // Skid drain with a concurrent offer.
    out_ready = 1'b0;
    offer(1'b1, 1'b0, 64'h7, 5'd7); step();
    offer(1'b1, 1'b0, 64'h8, 5'd8); step();
    chk("sk_full_occ", occupancy, 2);
    out_ready = 1'b1;
    offer(1'b1, 1'b0, 64'h9, 5'd9); step();
    chk("sk_drain_data", out_data, 64'h8);
    chk("sk_drain_occ", occupancy, 1);
    chk("sk_drain_in_ready", in_ready, 1);
    step();
    chk("sk_9_data", out_data, 64'h9);
    chk("sk_9_rd", out_rd, 9);
    chk("sk_9_occ", occupancy, 1);
    offer(1'b0, 1'b0, 64'h0, 5'd0); step();
    chk("sk_end_occ", occupancy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
